// File: rtl/matrix_pkg.sv
// Shared types and sizes for the LED matrix scan driver.
// Holds the frame layout, the scan state encoding and the matrix geometry.
package matrix_pkg;

   localparam int NROWS = 16;
   localparam int NCOLS = 16;

   typedef logic [NROWS-1:0][NCOLS-1:0] frame_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SCAN,
      BLANK
   } scan_state_t;

endpackage

// File: rtl/scan_tick_counter.sv
// Loadable down-counter used to time how long a row is driven and how long
// the matrix stays blank between rows. o_done is high while the count is zero,
// so loading N-1 yields a done indication on the N-th cycle after the load.
module scan_tick_counter #(
   parameter int W = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_loadVal,
   input  logic         i_dec,
   output logic         o_done
);

   logic [W-1:0] r_count;

   // Clear wins over load, load wins over decrement; the count never wraps below zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/matrix_scan_driver.sv
// Scans a 16x16 frame onto the LED matrix one row at a time.
// A shadow copy of the frame is taken only in the one-cycle LOAD state between
// frames, so a frame never tears mid-scan. Rows are separated by optional
// blanking cycles to suppress ghosting.
// Build option: define MATRIX_FLIP_EN to flip the image vertically
// (frame row 0 drives physical row 15); scan timing is unaffected.
module matrix_scan_driver
   import matrix_pkg::*;
#(
   parameter int ROW_DIV   = 4,
   parameter int BLANK_CYC = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_scanEn,
   input  frame_t      i_frameIn,
   input  logic        i_frameValid,
   output logic [15:0] o_rowSel,
   output logic [15:0] o_colData,
   output logic        o_frameLatched
);

   localparam int DIV_W = $clog2(ROW_DIV + 1);
   localparam int BLK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(ROW_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
   localparam logic [3:0] LAST_ROW = 4'(NROWS - 1);

   scan_state_t r_state;
   logic [3:0]  r_row;
   frame_t      r_shadow;
   logic        r_frameLatched;

   logic w_divDone;
   logic w_divLoad;
   logic w_divDec;
   logic w_blankDone;
   logic w_blankLoad;
   logic w_blankDec;
   logic w_clear;

   // Counter controls: the row timer restarts on every row entry, the blank timer on every row exit.
   always_comb begin
      w_clear     = ~i_scanEn;
      w_divLoad   = 1'b0;
      w_divDec    = 1'b0;
      w_blankLoad = 1'b0;
      w_blankDec  = 1'b0;
      if (i_scanEn) begin
         case (r_state)
            LOAD: begin
               w_divLoad = 1'b1;
            end
            SCAN: begin
               if (!w_divDone) begin
                  w_divDec = 1'b1;
               end else if (BLANK_CYC > 0) begin
                  w_blankLoad = 1'b1;
               end else if (r_row != LAST_ROW) begin
                  w_divLoad = 1'b1;
               end
            end
            BLANK: begin
               if (!w_blankDone) begin
                  w_blankDec = 1'b1;
               end else if (r_row != LAST_ROW) begin
                  w_divLoad = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   scan_tick_counter #(.W(DIV_W)) u_divCounter (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_clear),
      .i_load    (w_divLoad),
      .i_loadVal (DIV_LOAD),
      .i_dec     (w_divDec),
      .o_done    (w_divDone)
   );

   scan_tick_counter #(.W(BLK_W)) u_blankCounter (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_clear),
      .i_load    (w_blankLoad),
      .i_loadVal (BLK_LOAD),
      .i_dec     (w_blankDec),
      .o_done    (w_blankDone)
   );

   // Scan sequencer: dropping i_scanEn always returns to IDLE so a restart begins at a fresh LOAD.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= IDLE;
         r_row          <= 4'd0;
         r_shadow       <= '0;
         r_frameLatched <= 1'b0;
      end else begin
         r_frameLatched <= 1'b0;
         if (!i_scanEn) begin
            r_state <= IDLE;
            r_row   <= 4'd0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state <= LOAD;
               end
               LOAD: begin
                  if (i_frameValid) begin
                     r_shadow       <= i_frameIn;
                     r_frameLatched <= 1'b1;
                  end
                  r_row   <= 4'd0;
                  r_state <= SCAN;
               end
               SCAN: begin
                  if (w_divDone) begin
                     if (BLANK_CYC > 0) begin
                        r_state <= BLANK;
                     end else if (r_row != LAST_ROW) begin
                        r_row <= r_row + 4'd1;
                     end else begin
                        r_state <= LOAD;
                     end
                  end
               end
               BLANK: begin
                  if (w_blankDone) begin
                     if (r_row != LAST_ROW) begin
                        r_row   <= r_row + 4'd1;
                        r_state <= SCAN;
                     end else begin
                        r_state <= LOAD;
                     end
                  end
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   // Pin drive is decoded from registered state only, so the matrix is dark outside SCAN.
   always_comb begin
      o_rowSel  = 16'h0000;
      o_colData = 16'h0000;
      if (r_state == SCAN) begin
`ifdef MATRIX_FLIP_EN
         o_rowSel = 16'h8000 >> r_row;
`else
         o_rowSel = 16'h0001 << r_row;
`endif
         o_colData = r_shadow[r_row];
      end
   end

   assign o_frameLatched = r_frameLatched;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Self-checking bench for matrix_scan_driver.
// Two instances share stimulus: the default timing (4 drive / 1 blank) and a
// minimal one (1 drive / 0 blank). A frame-position model predicts outputs on
// every cycle; directed literal checks pin the model to hand-computed values.
module tb_matrix_scan_driver;
   import matrix_pkg::*;

   localparam int A_DIV = 4;
   localparam int A_BLK = 1;
   localparam int B_DIV = 1;
   localparam int B_BLK = 0;
`ifdef MATRIX_FLIP_EN
   localparam bit FLIP = 1'b1;
`else
   localparam bit FLIP = 1'b0;
`endif

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   scanEn = 1'b1;
   logic   frameValid = 1'b0;
   frame_t frameIn = '0;

   logic [15:0] rowSelA, colDataA, rowSelB, colDataB;
   logic        flA, flB;

   int testsRun = 0;
   int testsFailed = 0;

   bit     mRun [2];
   int     mT [2];
   frame_t mShadow [2];
   bit     mFl [2];

   always #5 clk = ~clk;

   matrix_scan_driver #(.ROW_DIV(A_DIV), .BLANK_CYC(A_BLK)) dutA (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_scanEn       (scanEn),
      .i_frameIn      (frameIn),
      .i_frameValid   (frameValid),
      .o_rowSel       (rowSelA),
      .o_colData      (colDataA),
      .o_frameLatched (flA)
   );

   matrix_scan_driver #(.ROW_DIV(B_DIV), .BLANK_CYC(B_BLK)) dutB (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_scanEn       (scanEn),
      .i_frameIn      (frameIn),
      .i_frameValid   (frameValid),
      .o_rowSel       (rowSelB),
      .o_colData      (colDataB),
      .o_frameLatched (flB)
   );

   function automatic int divOf(input int i);
      return (i == 0) ? A_DIV : B_DIV;
   endfunction

   function automatic int periodOf(input int i);
      return (i == 0) ? (A_DIV + A_BLK) : (B_DIV + B_BLK);
   endfunction

   function automatic logic [15:0] phys(input logic [15:0] v);
      logic [15:0] rv;
      rv = {<<{v}};
      return FLIP ? rv : v;
   endfunction

   function automatic logic [15:0] diagFrameRow(input int r);
      logic [15:0] one;
      one = 16'h0001;
      return one << r;
   endfunction

   // Expected row drive from the position inside the frame: cycle 0 is LOAD, then 16 slots of drive+blank.
   function automatic logic [15:0] expRowSel(input int i);
      int k;
      int r;
      if (!mRun[i] || mT[i] == 0) return 16'h0000;
      k = mT[i] - 1;
      r = k / periodOf(i);
      if ((k % periodOf(i)) >= divOf(i)) return 16'h0000;
      return phys(diagFrameRow(r));
   endfunction

   function automatic logic [15:0] expColData(input int i);
      int k;
      int r;
      if (!mRun[i] || mT[i] == 0) return 16'h0000;
      k = mT[i] - 1;
      r = k / periodOf(i);
      if ((k % periodOf(i)) >= divOf(i)) return 16'h0000;
      return mShadow[i][r];
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic setDiagonal();
      for (int r = 0; r < 16; r++) frameIn[r] = diagFrameRow(r);
   endtask

   task automatic waitLatch(input int inst, output int cyc);
      bit seen;
      seen = 1'b0;
      cyc = 0;
      for (int n = 0; n < 200; n++) begin
         step();
         cyc++;
         if ((inst == 0) ? flA : flB) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL latch timeout inst %0d: got none, expected pulse within 200 cycles", inst);
      end
   endtask

   // Frame-position model: advances once per clock from the inputs seen at that edge.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mRun[i] = 1'b0;
            mT[i] = 0;
            mFl[i] = 1'b0;
            mShadow[i] = '0;
         end else if (!scanEn) begin
            mRun[i] = 1'b0;
            mT[i] = 0;
            mFl[i] = 1'b0;
         end else if (!mRun[i]) begin
            mRun[i] = 1'b1;
            mT[i] = 0;
            mFl[i] = 1'b0;
         end else if (mT[i] == 0) begin
            mFl[i] = frameValid;
            if (frameValid) mShadow[i] = frameIn;
            mT[i] = 1;
         end else begin
            mFl[i] = 1'b0;
            mT[i] = (mT[i] == 16 * periodOf(i)) ? 0 : mT[i] + 1;
         end
      end
   end

   // Every-cycle comparison against the model; reset forces the dark state immediately.
   always @(negedge clk) begin
      checkOutput("A rowSel",  rowSelA,      rst ? 16'h0 : expRowSel(0));
      checkOutput("A colData", colDataA,     rst ? 16'h0 : expColData(0));
      checkOutput("A latched", {15'h0, flA}, rst ? 16'h0 : {15'h0, mFl[0]});
      checkOutput("B rowSel",  rowSelB,      rst ? 16'h0 : expRowSel(1));
      checkOutput("B colData", colDataB,     rst ? 16'h0 : expColData(1));
      checkOutput("B latched", {15'h0, flB}, rst ? 16'h0 : {15'h0, mFl[1]});
   end

   task automatic applyStimulus();
      int cyc;

      // Reset held with scan enabled: matrix stays dark.
      repeat (3) begin
         step();
         checkOutput("reset rowSel",  rowSelA, 16'h0000);
         checkOutput("reset colData", colDataA, 16'h0000);
         checkOutput("reset latched", {15'h0, flA}, 16'h0000);
      end

      // Diagonal frame, first frame and period.
      setDiagonal();
      frameValid = 1'b1;
      rst = 1'b0;
      waitLatch(0, cyc);
      checkOutput("first latch latency", 16'(cyc), 16'd2);
      checkOutput("diag row0 rowSel", rowSelA, phys(16'h0001));
      checkOutput("diag row0 colData", colDataA, 16'h0001);
      for (int k = 1; k <= 81; k++) begin
         step();
         case (k)
            3:  checkOutput("diag row0 last rowSel", rowSelA, phys(16'h0001));
            4:  checkOutput("diag blank rowSel", rowSelA, 16'h0000);
            5: begin
               checkOutput("diag row1 rowSel", rowSelA, phys(16'h0002));
               checkOutput("diag row1 colData", colDataA, 16'h0002);
            end
            75: begin
               checkOutput("diag row15 rowSel", rowSelA, phys(16'h8000));
               checkOutput("diag row15 colData", colDataA, 16'h8000);
            end
            79: checkOutput("diag last blank colData", colDataA, 16'h0000);
            80: checkOutput("diag load rowSel", rowSelA, 16'h0000);
            81: begin
               checkOutput("period 81 latched", {15'h0, flA}, 16'h0001);
               checkOutput("frame2 row0 rowSel", rowSelA, phys(16'h0001));
            end
            default: begin
            end
         endcase
      end

      // No tearing: new frame data arrives while row 7 is on.
      for (int k = 1; k <= 81; k++) begin
         step();
         if (k == 35) begin
            checkOutput("tear row7 colData", colDataA, 16'h0080);
            for (int r = 0; r < 16; r++) frameIn[r] = 16'hFFFF;
         end else if (k == 50) begin
            checkOutput("tear row10 colData", colDataA, 16'h0400);
         end else if (k == 75) begin
            checkOutput("tear row15 colData", colDataA, 16'h8000);
         end else if (k == 81) begin
            checkOutput("new frame latched", {15'h0, flA}, 16'h0001);
            checkOutput("new frame row0 colData", colDataA, 16'hFFFF);
            setDiagonal();
            frameValid = 1'b0;
         end
      end

      // Hold: no valid frame at LOAD keeps the previous shadow.
      for (int k = 1; k <= 81; k++) begin
         step();
         if (k == 40) checkOutput("hold row8 colData", colDataA, 16'hFFFF);
         if (k == 81) begin
            checkOutput("hold no latch", {15'h0, flA}, 16'h0000);
            checkOutput("hold row0 colData", colDataA, 16'hFFFF);
         end
      end

      // Abort during row 5, then restart from a fresh LOAD.
      for (int k = 1; k <= 26; k++) step();
      checkOutput("abort row5 rowSel", rowSelA, phys(16'h0020));
      scanEn = 1'b0;
      step();
      checkOutput("abort dark rowSel", rowSelA, 16'h0000);
      checkOutput("abort dark colData", colDataA, 16'h0000);
      repeat (3) step();
      checkOutput("idle dark rowSel", rowSelA, 16'h0000);
      frameValid = 1'b1;
      scanEn = 1'b1;
      waitLatch(0, cyc);
      checkOutput("restart latency", 16'(cyc), 16'd2);
      checkOutput("restart rowSel", rowSelA, phys(16'h0001));
      checkOutput("restart colData", colDataA, 16'h0001);

      // Instance B latched in the same cycle: a new row every cycle, 17-cycle frame.
      checkOutput("B restart latched", {15'h0, flB}, 16'h0001);
      checkOutput("B row0 rowSel", rowSelB, phys(16'h0001));
      for (int k = 1; k <= 17; k++) begin
         step();
         if (k <= 15) begin
            checkOutput("B gapless rowSel", rowSelB, phys(diagFrameRow(k)));
            checkOutput("B gapless colData", colDataB, diagFrameRow(k));
         end else if (k == 16) begin
            checkOutput("B load rowSel", rowSelB, 16'h0000);
         end else begin
            checkOutput("B period 17 latched", {15'h0, flB}, 16'h0001);
         end
      end

      // Reset mid-scan darkens the matrix without waiting for a clock.
      repeat (7) step();
      rst = 1'b1;
      #1;
      checkOutput("async reset rowSel", rowSelA, 16'h0000);
      checkOutput("async reset colData", colDataA, 16'h0000);
      step();
      rst = 1'b0;
      repeat (30) step();
   endtask

   initial begin
      applyStimulus();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
